// File: rtl/array_mem_pkg.sv
// Shared definitions for the Array request/response port: default widths,
// the interface field list and a small address range helper.
package array_mem_pkg;

  localparam int unsigned INT_N   = 32;
  localparam int unsigned ADDR_N  = 10;
  localparam int unsigned WORDS_N = 1024;

  typedef enum logic [2:0] {
    FIELD_ADDR  = 3'd0,
    FIELD_WE    = 3'd1,
    FIELD_DIN   = 3'd2,
    FIELD_DOUT  = 3'd3,
    FIELD_VALID = 3'd4,
    FIELD_READY = 3'd5
  } array_field_e;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [ADDR_N-1:0] addr;
    logic [INT_N-1:0]  din;
  } array_req_t;

  typedef struct packed {
    logic             ready;
    logic [INT_N-1:0] dout;
  } array_rsp_t;

  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned words);
    return (addr < words);
  endfunction

endpackage

// File: rtl/array_mem_core.sv
// Plain N x DN register array with a registered, read-before-write output.
// The caller guarantees addr is in range whenever en is high.
module array_mem_core
  import array_mem_pkg::*;
#(
  parameter int unsigned N  = WORDS_N,
  parameter int unsigned AN = ADDR_N,
  parameter int unsigned DN = INT_N
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          en,
  input  logic          we,
  input  logic [AN-1:0] addr,
  input  logic [DN-1:0] din,
  output logic [DN-1:0] rdata
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [DN-1:0] mem [N];
  logic [IW-1:0] idx;
  logic [DN-1:0] rdata_d;
  logic [DN-1:0] rdata_q;

  assign idx = addr[IW-1:0];

  // clr wins over en so a reset or out-of-range access forces a zero word.
  always_comb begin
    rdata_d = rdata_q;
    if (clr) begin
      rdata_d = '0;
    end else if (en) begin
      rdata_d = mem[idx];
    end
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[idx] <= din;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/array_mem.sv
// Single-port word memory behind the Array valid/ready port: one-cycle
// latency, one request per cycle, no backpressure.
module array_mem
  import array_mem_pkg::*;
#(
  parameter int unsigned N  = WORDS_N,
  parameter int unsigned AN = ADDR_N,
  parameter int unsigned DN = INT_N
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid,
  input  logic [AN-1:0] addr,
  input  logic          we,
  input  logic [DN-1:0] din,
  output logic [DN-1:0] dout,
  output logic          ready
);

  logic accept;
  logic in_range;
  logic core_en;
  logic core_clr;
  logic ready_d;
  logic ready_q;

  // A request in a reset cycle is dropped entirely; valid gates every other
  // input so idle-cycle garbage can never reach the array.
  always_comb begin
    accept   = valid && !rst;
    in_range = addr_in_range(32'(addr), N);
    core_en  = accept && in_range;
    core_clr = rst || (accept && !in_range);
    ready_d  = accept;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= ready_d;
    end
  end

  array_mem_core #(
    .N (N),
    .AN(AN),
    .DN(DN)
  ) u_core (
    .clk  (clk),
    .clr  (core_clr),
    .en   (core_en),
    .we   (we),
    .addr (addr),
    .din  (din),
    .rdata(dout)
  );

  assign ready = ready_q;

endmodule

// File: tb/tb_array_mem.sv
// Randomized self-checking bench for array_mem against an associative-array
// model of the memory; a second instance with N = 1000 covers out-of-range.
module tb_array_mem;

  localparam int unsigned N  = 1024;
  localparam int unsigned AN = 10;
  localparam int unsigned DN = 32;
  localparam int unsigned N2 = 1000;

  typedef struct {
    logic          v;
    logic          w;
    int unsigned   a;
    logic [DN-1:0] d;
  } op_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid;
  logic          we;
  logic [AN-1:0] addr;
  logic [DN-1:0] din;
  logic [DN-1:0] dout;
  logic          ready;

  logic          valid2;
  logic          we2;
  logic [AN-1:0] addr2;
  logic [DN-1:0] din2;
  logic [DN-1:0] dout2;
  logic          ready2;

  int checks   = 0;
  int failures = 0;

  logic [DN-1:0] model  [int unsigned];
  logic [DN-1:0] model2 [int unsigned];
  logic          exp_ready;
  logic [DN-1:0] exp_dout;
  logic          exp_known;

  always #5 clk = ~clk;

  array_mem #(.N(N), .AN(AN), .DN(DN)) dut (
    .clk  (clk),
    .rst  (rst),
    .valid(valid),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .ready(ready)
  );

  array_mem #(.N(N2), .AN(AN), .DN(DN)) dut_oor (
    .clk  (clk),
    .rst  (rst),
    .valid(valid2),
    .addr (addr2),
    .we   (we2),
    .din  (din2),
    .dout (dout2),
    .ready(ready2)
  );

  // Present one request (or an idle cycle with random junk on the ignored
  // inputs) and record what the model says the response must be.
  task automatic drive(input op_t op);
    valid = op.v;
    if (op.v) begin
      we        = op.w;
      addr      = AN'(op.a);
      din       = op.d;
      exp_ready = 1'b1;
      if (model.exists(op.a)) begin
        exp_known = 1'b1;
        exp_dout  = model[op.a];
      end else begin
        exp_known = 1'b0;
      end
      if (op.w) model[op.a] = op.d;
    end else begin
      we        = 1'($urandom);
      addr      = AN'($urandom);
      din       = $urandom;
      exp_ready = 1'b0;
    end
  endtask

  function automatic op_t mk(input logic v, input logic w, input int unsigned a, input logic [DN-1:0] d);
    op_t o;
    o.v = v; o.w = w; o.a = a; o.d = d;
    return o;
  endfunction

  task automatic test_reset;
    rst = 1'b1; valid = 1'b1; we = 1'b1; addr = AN'(5); din = 32'd99;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_ready got=%0b want=0", ready);
      end
      checks++;
      if (dout !== '0) begin
        failures++;
        $display("[TB] FAIL reset_dout got=%08h want=00000000", dout);
      end
    end
    rst = 1'b0;
    exp_ready = 1'b0; exp_dout = '0; exp_known = 1'b1;
    drive(mk(1'b1, 1'b0, 5, '0));
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_read5_ready got=%0b want=1", ready);
    end
    checks++;
    if (dout === 32'd99) begin
      failures++;
      $display("[TB] FAIL reset_read5_dout got=%08h want=not 00000063", dout);
    end
    drive(mk(1'b0, 1'b0, 0, '0));
  endtask

  task automatic test_fill_readback;
    op_t ops[$];
    for (int i = 0; i < int'(N); i++) begin
      if ($urandom_range(0, 1) == 1) ops.push_back(mk(1'b0, 1'b0, 0, '0));
      ops.push_back(mk(1'b1, 1'b1, i, DN'(i)));
    end
    for (int i = 0; i < int'(N); i++) begin
      if ($urandom_range(0, 1) == 1) ops.push_back(mk(1'b0, 1'b0, 0, '0));
      ops.push_back(mk(1'b1, 1'b0, i, '0));
    end
    for (int k = 0; k <= ops.size(); k++) begin
      @(negedge clk);
      if (k > 0) begin
        checks++;
        if (ready !== exp_ready) begin
          failures++;
          $display("[TB] FAIL fill_ready step=%0d got=%0b want=%0b", k, ready, exp_ready);
        end
        if (exp_known) begin
          checks++;
          if (dout !== exp_dout) begin
            failures++;
            $display("[TB] FAIL fill_dout step=%0d got=%08h want=%08h", k, dout, exp_dout);
          end
        end
      end
      if (k < ops.size()) drive(ops[k]);
      else drive(mk(1'b0, 1'b0, 0, '0));
    end
  endtask

  task automatic test_read_before_write;
    logic [DN-1:0] first_old;
    @(negedge clk);
    first_old = model[7];
    drive(mk(1'b1, 1'b1, 7, 32'd10));
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || dout !== first_old) begin
      failures++;
      $display("[TB] FAIL rbw_first ready=%0b dout=%08h want ready=1 dout=%08h", ready, dout, first_old);
    end
    drive(mk(1'b1, 1'b1, 7, 32'd20));
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || dout !== 32'd10) begin
      failures++;
      $display("[TB] FAIL rbw_second ready=%0b dout=%08h want ready=1 dout=0000000a", ready, dout);
    end
    drive(mk(1'b1, 1'b0, 7, '0));
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || dout !== 32'd20) begin
      failures++;
      $display("[TB] FAIL rbw_read ready=%0b dout=%08h want ready=1 dout=00000014", ready, dout);
    end
    drive(mk(1'b0, 1'b0, 0, '0));
    @(negedge clk);
    checks++;
    if (ready !== 1'b0 || dout !== 32'd20) begin
      failures++;
      $display("[TB] FAIL rbw_idle_hold ready=%0b dout=%08h want ready=0 dout=00000014", ready, dout);
    end
  endtask

  task automatic test_back_to_back;
    drive(mk(1'b1, 1'b1, 3, 32'hDEADBEEF));
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_ready_t1 got=%0b want=1", ready);
    end
    drive(mk(1'b1, 1'b0, 3, '0));
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || dout !== 32'hDEADBEEF) begin
      failures++;
      $display("[TB] FAIL b2b_read ready=%0b dout=%08h want ready=1 dout=deadbeef", ready, dout);
    end
    drive(mk(1'b0, 1'b0, 0, '0));
    @(negedge clk);
    checks++;
    if (ready !== 1'b0 || dout !== 32'hDEADBEEF) begin
      failures++;
      $display("[TB] FAIL b2b_idle ready=%0b dout=%08h want ready=0 dout=deadbeef", ready, dout);
    end
  endtask

  task automatic test_reset_mid_stream;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (k > 0) begin
        checks++;
        if (ready !== exp_ready) begin
          failures++;
          $display("[TB] FAIL midrst_ready step=%0d got=%0b want=%0b", k, ready, exp_ready);
        end
        if (exp_known) begin
          checks++;
          if (dout !== exp_dout) begin
            failures++;
            $display("[TB] FAIL midrst_dout step=%0d got=%08h want=%08h", k, dout, exp_dout);
          end
        end
      end
      rst = 1'b0;
      if (k == 20) begin
        drive(mk(1'b0, 1'b0, 0, '0));
      end else if (k == 10) begin
        rst = 1'b1; valid = 1'b1; we = 1'b1; addr = AN'(200); din = ~model[200];
        exp_ready = 1'b0; exp_dout = '0; exp_known = 1'b1;
      end else if (k == 5) begin
        drive(mk(1'b1, 1'b1, 100, $urandom));
      end else if (k == 15) begin
        drive(mk(1'b1, 1'b0, 100, '0));
      end else if (k == 17) begin
        drive(mk(1'b1, 1'b0, 200, '0));
      end else begin
        drive(mk(1'b1, 1'b0, $urandom_range(0, N - 1), '0));
      end
    end
  endtask

  task automatic test_out_of_range;
    op_t           ops[$];
    logic          exp2_ready;
    logic [DN-1:0] exp2_dout;
    logic          exp2_known;
    exp2_ready = 1'b0; exp2_dout = '0; exp2_known = 1'b0;
    for (int i = 0; i < int'(N2); i++) ops.push_back(mk(1'b1, 1'b1, i, $urandom));
    ops.push_back(mk(1'b1, 1'b1, 1010, 32'd5));
    ops.push_back(mk(1'b1, 1'b0, 1010, '0));
    ops.push_back(mk(1'b1, 1'b1, 1023, 32'd7));
    ops.push_back(mk(1'b1, 1'b0, 1023, '0));
    for (int i = 0; i < int'(N2); i++) ops.push_back(mk(1'b1, 1'b0, i, '0));
    for (int k = 0; k <= ops.size(); k++) begin
      @(negedge clk);
      if (k > 0) begin
        checks++;
        if (ready2 !== exp2_ready) begin
          failures++;
          $display("[TB] FAIL oor_ready step=%0d got=%0b want=%0b", k, ready2, exp2_ready);
        end
        if (exp2_known) begin
          checks++;
          if (dout2 !== exp2_dout) begin
            failures++;
            $display("[TB] FAIL oor_dout step=%0d got=%08h want=%08h", k, dout2, exp2_dout);
          end
        end
      end
      if (k < ops.size()) begin
        valid2 = 1'b1; we2 = ops[k].w; addr2 = AN'(ops[k].a); din2 = ops[k].d;
        exp2_ready = 1'b1;
        if (ops[k].a >= N2) begin
          exp2_known = !ops[k].w;
          exp2_dout  = '0;
        end else begin
          exp2_known = model2.exists(ops[k].a);
          if (exp2_known) exp2_dout = model2[ops[k].a];
          if (ops[k].w) model2[ops[k].a] = ops[k].d;
        end
      end else begin
        valid2 = 1'b0; we2 = 1'($urandom); addr2 = AN'($urandom); din2 = $urandom;
      end
    end
  endtask

  initial begin
    valid2 = 1'b0; we2 = 1'b0; addr2 = '0; din2 = '0;
    test_reset();
    test_fill_readback();
    test_read_before_write();
    test_back_to_back();
    test_reset_mid_stream();
    test_out_of_range();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
